ysyx_25050147_load_unit: RTL
============================

Name: ysyx_25050147_load_unit

Overview:
- Sequential, parametrised load unit between the EXU/LSU stage and the data-memory read bus.
- Accepts one load request at a time (opcode, byte address) over a valid/ready handshake and issues one or two aligned bus reads.
- Extracts and zero- or sign-extends the addressed byte, half, word or double (XLEN=64), then returns the result over a valid/ready response handshake.
- Misaligned loads that cross a bus word are split into two beats and merged.

Parameters:
- XLEN, 32, datapath and bus data width; legal values 32 or 64.
- AW, 32, address width.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- req_valid  input  1  load request valid.
- req_ready  output  1  unit can accept a request; high only in IDLE.
- req_op  input  3  funct3 encoding: 000 LB, 001 LH, 010 LW, 011 LD, 100 LBU, 101 LHU, 110 LWU.
- req_addr  input  AW  byte address.
- resp_valid  output  1  result valid.
- resp_ready  input  1  consumer accepts result.
- resp_data  output  XLEN  extended load result.
- resp_err  output  1  access fault or illegal op.
- mem_arvalid  output  1  bus read-address valid.
- mem_arready  input  1  bus read-address accepted.
- mem_araddr  output  AW  aligned bus address.
- mem_rvalid  input  1  bus read data valid.
- mem_rready  output  1  unit accepts read data.
- mem_rdata  input  XLEN  bus read data.
- mem_rresp  input  1  1 = bus error on this beat.

Behaviour:
- Reset (rst_n low, async):
  - state = IDLE.
  - resp_valid=0, resp_data=0, resp_err=0, mem_arvalid=0, mem_rready=0, mem_araddr=0.
  - Any in-flight bus transaction is abandoned; the memory side is reset by the same rst_n.
- Request acceptance and decode:
  - Request is accepted when req_valid && req_ready. req_op and req_addr are registered; inputs are ignored afterwards.
  - B = XLEN/8. off = addr mod B. size = 1/2/4/8 bytes from op[1:0].
  - Illegal op: 111; 011 or 110 when XLEN=32.
  - Split is needed when off+size > B.
- States:
  - IDLE: req_ready=1. On accept, go to AR0, or to RESP with resp_err=1, resp_data=0 for an illegal op.
  - AR0: mem_arvalid=1, mem_araddr = addr with low log2(B) bits cleared. Hold araddr stable until mem_arready, then go to R0.
  - R0: mem_rready=1. On mem_rvalid, capture beat0 and OR mem_rresp into the error flag. Go to AR1 if split, else RESP.
  - AR1: mem_araddr = beat0 address + B, wrapping modulo 2^AW. On mem_arready, go to R1.
  - R1: on mem_rvalid, capture beat1, OR in error, go to RESP.
  - RESP: resp_valid=1; resp_data and resp_err are held stable until resp_ready, then go to IDLE.
- Extraction:
  - raw = ({beat1, beat0} >> (8*off)), low size bytes. beat1 is taken as 0 when there is no split.
  - Ops 000/001/010/011 sign-extend to XLEN; 100/101/110 zero-extend.
- Errors:
  - If either beat returns mem_rresp=1, the response is resp_err=1, resp_data=0. The second beat is still issued and drained, so the bus stays consistent.
- Latency (zero-wait bus), accept in cycle T:
  - Aligned: AR handshake T+1, R at T+2, resp_valid from T+3.
  - Split: resp_valid from T+5.
  - Illegal op: resp_valid at T+1.
- Concurrency:
  - One outstanding request only. No new accept in the RESP cycle; earliest next accept is the cycle after the resp handshake.
  - mem_rvalid is ignored outside R0/R1.
- resp_data and resp_err retain their last values while not in RESP. They are only meaningful when resp_valid=1.

Optional Feature:
- Macro: LOAD_UNIT_MISALIGN_SPLIT_EN
- Defined: split behaviour as above.
- Undefined:
  - Any request with off+size > B goes directly from IDLE to RESP with resp_err=1, resp_data=0, and issues no bus access.
  - AR1/R1 states are not built.
  - Aligned behaviour is unchanged.

Test Plan:
- XLEN=32: LB addr 0x1003, rdata 0x80FF_0000 -> araddr 0x1000, resp_data 0xFFFF_FF80, resp_err 0; resp_valid 3 cycles after accept.
- XLEN=32: LHU addr 0x2002, rdata 0xBEEF_1234 -> resp_data 0x0000_BEEF; with resp_ready held low 4 cycles, resp_data is stable throughout and req_ready=0.
- XLEN=32, split enabled: LW addr 0x3003, beat0 0x11xx_xxxx, beat1 0xxx44_3322 -> araddr 0x3000 then 0x3004, resp_data 0x4433_2211.
- Split disabled: the same LW 0x3003 -> no mem_arvalid, resp_err=1, resp_data 0 at accept+1.
- XLEN=64: LD addr 0x8 with mem_rresp=1 -> resp_err=1, resp_data 0. Then op 111 -> resp_err=1 with no bus access.
- Assert rst_n low during R0 with mem_arvalid history pending -> all outputs 0 immediately; after release, req_ready=1 and the next LW completes normally.

Source files
------------

// File: rtl/ysyx_25050147_load_unit_if.sv
// Load-unit bundle: LSU request/response handshakes plus the data-memory read bus.
// slave = the load unit's view; master = the LSU stage / memory model driving it.
interface ysyx_25050147_load_unit_if #(
    parameter int XLEN = 32,
    parameter int AW   = 32
);
    logic            req_valid;
    logic            req_ready;
    logic [2:0]      req_op;
    logic [AW-1:0]   req_addr;
    logic            resp_valid;
    logic            resp_ready;
    logic [XLEN-1:0] resp_data;
    logic            resp_err;
    logic            mem_arvalid;
    logic            mem_arready;
    logic [AW-1:0]   mem_araddr;
    logic            mem_rvalid;
    logic            mem_rready;
    logic [XLEN-1:0] mem_rdata;
    logic            mem_rresp;

    modport slave (
        input  req_valid, req_op, req_addr, resp_ready,
               mem_arready, mem_rvalid, mem_rdata, mem_rresp,
        output req_ready, resp_valid, resp_data, resp_err,
               mem_arvalid, mem_araddr, mem_rready
    );

    modport master (
        output req_valid, req_op, req_addr, resp_ready,
               mem_arready, mem_rvalid, mem_rdata, mem_rresp,
        input  req_ready, resp_valid, resp_data, resp_err,
               mem_arvalid, mem_araddr, mem_rready
    );
endinterface

// File: rtl/ysyx_25050147_load_unit.sv
// Single-outstanding load unit: aligned bus reads, byte/half/word/double extraction.
// Define LOAD_UNIT_MISALIGN_SPLIT_EN to split bus-word-crossing loads into two beats.
module ysyx_25050147_load_unit #(
    parameter int XLEN = 32,
    parameter int AW   = 32
) (
    input logic                       clk,
    input logic                       rst_n,
    ysyx_25050147_load_unit_if.slave  lsu
);
    localparam int B  = XLEN / 8;
    localparam int OW = $clog2(B);

    typedef enum logic [2:0] {
        S_IDLE,
        S_AR0,
        S_R0,
`ifdef LOAD_UNIT_MISALIGN_SPLIT_EN
        S_AR1,
        S_R1,
`endif
        S_RESP
    } state_t;

    state_t          state_q;
    logic [2:0]      op_q;
    logic [OW-1:0]   off_q;
    logic [AW-1:0]   araddr_q;
    logic            arvalid_q;
    logic            rready_q;
    logic            resp_valid_q;
    logic [XLEN-1:0] resp_data_q;
    logic            resp_err_q;
`ifdef LOAD_UNIT_MISALIGN_SPLIT_EN
    logic            split_q;
    logic            err_q;
    logic [XLEN-1:0] beat0_q;
`endif

    logic [OW-1:0] req_off;
    logic [4:0]    req_end;
    logic          req_split;
    logic          req_illegal;
    logic          req_reject;

    assign req_off     = lsu.req_addr[OW-1:0];
    assign req_end     = 5'(req_off) + (5'd1 << lsu.req_op[1:0]);
    assign req_split   = req_end > 5'(B);
    assign req_illegal = (lsu.req_op == 3'b111) ||
                         ((XLEN == 32) && (lsu.req_op == 3'b011 || lsu.req_op == 3'b110));
`ifdef LOAD_UNIT_MISALIGN_SPLIT_EN
    assign req_reject  = req_illegal;
`else
    assign req_reject  = req_illegal | req_split;
`endif

    // Left-justify the field, then shift back logically or arithmetically to extend.
    function automatic logic [XLEN-1:0] extract(input logic [2:0] op, input logic [OW-1:0] off,
                                                input logic [XLEN-1:0] hi, input logic [XLEN-1:0] lo);
        logic [2*XLEN-1:0] cat;
        logic [XLEN-1:0]   tmp;
        logic [7:0]        sh;
        cat = {hi, lo} >> {off, 3'b000};
        sh  = 8'(XLEN) - (8'd8 << op[1:0]);
        tmp = cat[XLEN-1:0] << sh;
        if (op[2]) extract = tmp >> sh;
        else       extract = $signed(tmp) >>> sh;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            op_q         <= '0;
            off_q        <= '0;
            araddr_q     <= '0;
            arvalid_q    <= 1'b0;
            rready_q     <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_data_q  <= '0;
            resp_err_q   <= 1'b0;
`ifdef LOAD_UNIT_MISALIGN_SPLIT_EN
            split_q      <= 1'b0;
            err_q        <= 1'b0;
            beat0_q      <= '0;
`endif
        end else begin
            case (state_q)
                S_IDLE: if (lsu.req_valid) begin
                    op_q     <= lsu.req_op;
                    off_q    <= req_off;
                    araddr_q <= {lsu.req_addr[AW-1:OW], {OW{1'b0}}};
`ifdef LOAD_UNIT_MISALIGN_SPLIT_EN
                    split_q  <= req_split;
                    err_q    <= 1'b0;
`endif
                    if (req_reject) begin
                        state_q      <= S_RESP;
                        resp_valid_q <= 1'b1;
                        resp_err_q   <= 1'b1;
                        resp_data_q  <= '0;
                    end else begin
                        state_q   <= S_AR0;
                        arvalid_q <= 1'b1;
                    end
                end
                S_AR0: if (lsu.mem_arready) begin
                    arvalid_q <= 1'b0;
                    rready_q  <= 1'b1;
                    state_q   <= S_R0;
                end
                S_R0: if (lsu.mem_rvalid) begin
                    rready_q <= 1'b0;
`ifdef LOAD_UNIT_MISALIGN_SPLIT_EN
                    if (split_q) begin
                        beat0_q   <= lsu.mem_rdata;
                        err_q     <= lsu.mem_rresp;
                        arvalid_q <= 1'b1;
                        araddr_q  <= araddr_q + AW'(B);
                        state_q   <= S_AR1;
                    end else
`endif
                    begin
                        state_q      <= S_RESP;
                        resp_valid_q <= 1'b1;
                        resp_err_q   <= lsu.mem_rresp;
                        resp_data_q  <= lsu.mem_rresp ? '0 : extract(op_q, off_q, '0, lsu.mem_rdata);
                    end
                end
`ifdef LOAD_UNIT_MISALIGN_SPLIT_EN
                S_AR1: if (lsu.mem_arready) begin
                    arvalid_q <= 1'b0;
                    rready_q  <= 1'b1;
                    state_q   <= S_R1;
                end
                // Second beat is drained even after a first-beat error to keep the bus in step.
                S_R1: if (lsu.mem_rvalid) begin
                    rready_q     <= 1'b0;
                    state_q      <= S_RESP;
                    resp_valid_q <= 1'b1;
                    resp_err_q   <= err_q | lsu.mem_rresp;
                    resp_data_q  <= (err_q | lsu.mem_rresp) ? '0
                                    : extract(op_q, off_q, lsu.mem_rdata, beat0_q);
                end
`endif
                S_RESP: if (lsu.resp_ready) begin
                    resp_valid_q <= 1'b0;
                    state_q      <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign lsu.req_ready   = (state_q == S_IDLE);
    assign lsu.resp_valid  = resp_valid_q;
    assign lsu.resp_data   = resp_data_q;
    assign lsu.resp_err    = resp_err_q;
    assign lsu.mem_arvalid = arvalid_q;
    assign lsu.mem_araddr  = araddr_q;
    assign lsu.mem_rready  = rready_q;
endmodule
